rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rf_wb_arbiter                                              |
// | Description : Two-requester register-file writeback arbiter with per-    |
// |               requester 2-entry FIFOs, round-robin grant and hazard      |
// |               query. Optional forwarding under macro RF_WB_BYPASS_EN.    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module rf_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  rd1_addr,
    input  logic [4:0]  rd2_addr,
    output logic        rd1_pending,
    output logic        rd2_pending,
`ifdef RF_WB_BYPASS_EN
    output logic        rd1_fwd_valid,
    output logic [31:0] rd1_fwd_data,
    output logic        rd2_fwd_valid,
    output logic [31:0] rd2_fwd_data,
`endif
    output logic        busy
);

    localparam logic [1:0] c_depth = 2'd2;

    // Index 0 is requester A, index 1 is requester B.
    logic [4:0]  r_addr  [2][2];
    logic [31:0] r_data  [2][2];
    logic        r_wptr  [2];
    logic        r_rptr  [2];
    logic [1:0]  r_cnt   [2];
    logic        r_last_b;
    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;

    logic [1:0]  w_in_valid;
    logic [4:0]  w_in_addr [2];
    logic [31:0] w_in_data [2];
    logic [1:0]  w_ready;
    logic [1:0]  w_push;
    logic [1:0]  w_head;
    logic [1:0]  w_grant;
    logic        w_sel;
    logic [4:0]  w_head_addr;
    logic [31:0] w_head_data;
    logic [1:0]  w_ent_valid [2];
    logic [4:0]  w_rd_addr [2];
    logic [1:0]  w_fmatch [2];
    logic [1:0]  w_omatch;
    logic [1:0]  w_pend;

    assign w_in_valid   = {b_valid, a_valid};
    assign w_in_addr[0] = a_addr;
    assign w_in_addr[1] = b_addr;
    assign w_in_data[0] = a_data;
    assign w_in_data[1] = b_data;
    assign w_rd_addr[0] = rd1_addr;
    assign w_rd_addr[1] = rd2_addr;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_ready[i]     = (r_cnt[i] < c_depth);
            w_push[i]      = w_in_valid[i] & w_ready[i];
            w_head[i]      = (r_cnt[i] != 2'd0);
            w_ent_valid[i] = 2'b00;
            for (int j = 0; j < 2; j++) begin
                w_ent_valid[i][j] = (r_cnt[i] == c_depth) ||
                                    ((r_cnt[i] == 2'd1) && (r_rptr[i] == j[0]));
            end
        end
    end

    // A wins a tie only when B was granted last.
    assign w_grant[0]  = w_head[0] & (~w_head[1] | r_last_b);
    assign w_grant[1]  = w_head[1] & ~w_grant[0];
    assign w_sel       = w_grant[1];
    assign w_head_addr = r_addr[w_sel][r_rptr[w_sel]];
    assign w_head_data = r_data[w_sel][r_rptr[w_sel]];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_addr[i][r_wptr[i]] <= w_in_addr[i];
                r_data[i][r_wptr[i]] <= w_in_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_wptr[i] <= 1'b0;
                r_rptr[i] <= 1'b0;
                r_cnt[i]  <= 2'd0;
            end
            r_last_b <= 1'b1;
            r_we     <= 1'b0;
            r_waddr  <= 5'd0;
            r_wdata  <= 32'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i])  r_wptr[i] <= ~r_wptr[i];
                if (w_grant[i]) r_rptr[i] <= ~r_rptr[i];
                case ({w_push[i], w_grant[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 2'd1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 2'd1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
            if (|w_grant) begin
                r_we     <= (w_head_addr != 5'd0);
                r_waddr  <= w_head_addr;
                r_wdata  <= w_head_data;
                r_last_b <= w_grant[1];
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_fmatch[p] = 2'b00;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    if (w_ent_valid[i][j] && (r_addr[i][j] == w_rd_addr[p]))
                        w_fmatch[p][i] = 1'b1;
                end
            end
            w_omatch[p] = r_we && (r_waddr == w_rd_addr[p]);
            w_pend[p]   = rst_n && (w_rd_addr[p] != 5'd0) &&
                          ((|w_fmatch[p]) || w_omatch[p]);
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic [1:0]  w_fwd_v;
    logic [31:0] w_fwd_d [2];

    // Youngest match wins: FIFO tail, then FIFO head, then output register.
    // Hits in both FIFOs have no single ordering, so the consumer must stall.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_fwd_v[p] = 1'b0;
            w_fwd_d[p] = 32'd0;
            if (w_pend[p] && !(&w_fmatch[p])) begin
                w_fwd_v[p] = 1'b1;
                if (|w_fmatch[p]) begin
                    for (int i = 0; i < 2; i++) begin
                        if (w_fmatch[p][i]) begin
                            if ((r_cnt[i] == c_depth) &&
                                (r_addr[i][~r_wptr[i]] == w_rd_addr[p]))
                                w_fwd_d[p] = r_data[i][~r_wptr[i]];
                            else
                                w_fwd_d[p] = r_data[i][r_rptr[i]];
                        end
                    end
                end else begin
                    w_fwd_d[p] = r_wdata;
                end
            end
        end
    end

    assign rd1_fwd_valid = w_fwd_v[0];
    assign rd1_fwd_data  = w_fwd_d[0];
    assign rd2_fwd_valid = w_fwd_v[1];
    assign rd2_fwd_data  = w_fwd_d[1];
`endif

    assign a_ready     = w_ready[0];
    assign b_ready     = w_ready[1];
    assign rf_we       = r_we;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;
    assign rd1_pending = w_pend[0];
    assign rd2_pending = w_pend[1];
    assign busy        = (r_cnt[0] != 2'd0) || (r_cnt[1] != 2'd0) || r_we;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rf_wb_arbiter                                           |
// | Description : Directed self-checking bench for rf_wb_arbiter.            |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rd1_addr, rd2_addr;
    logic        rd1_pending, rd2_pending;
    logic        busy;
`ifdef RF_WB_BYPASS_EN
    logic        rd1_fwd_valid, rd2_fwd_valid;
    logic [31:0] rd1_fwd_data, rd2_fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_pending(rd1_pending), .rd2_pending(rd2_pending),
`ifdef RF_WB_BYPASS_EN
        .rd1_fwd_valid(rd1_fwd_valid), .rd1_fwd_data(rd1_fwd_data),
        .rd2_fwd_valid(rd2_fwd_valid), .rd2_fwd_data(rd2_fwd_data),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd1_addr = 5'd5; rd2_addr = 5'd0;
        #3;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b exp 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d exp 0", rf_waddr); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", rf_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        checks++; if (rd1_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b exp 0", rd1_pending); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if ({a_ready, b_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b exp 11", {a_ready, b_ready}); end
    endtask

    task automatic test_tie();
        a_valid = 1; a_addr = 5'd3; a_data = 32'hA;
        b_valid = 1; b_addr = 5'd4; b_data = 32'hB;
        tick();
        a_data = 32'hC; b_data = 32'hD;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL tie_latency: got we=%0b exp 0", rf_we); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tie_busy: got %0b exp 1", busy); end
        tick();
        a_valid = 0; b_valid = 0;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'hA}) begin errors++; $display("FAIL tie_first_a: got we=%0b addr=%0d data=%h exp 1/3/a", rf_we, rf_waddr, rf_wdata); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL tie_b_full: got b_ready=%0b exp 0", b_ready); end
        tick();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'hB}) begin errors++; $display("FAIL tie_then_b: got we=%0b addr=%0d data=%h exp 1/4/b", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'hC}) begin errors++; $display("FAIL tie_second_a: got we=%0b addr=%0d data=%h exp 1/3/c", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'hD}) begin errors++; $display("FAIL tie_second_b: got we=%0b addr=%0d data=%h exp 1/4/d", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if ({rf_we, rf_waddr, busy} !== {1'b0, 5'd4, 1'b0}) begin errors++; $display("FAIL tie_idle_hold: got we=%0b addr=%0d busy=%0b exp 0/4/0", rf_we, rf_waddr, busy); end
    endtask

    task automatic test_single();
        a_valid = 1; a_addr = 5'd5; a_data = 32'h64;
        tick();
        a_valid = 0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_edge1: got we=%0b exp 0", rf_we); end
        tick();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h64}) begin errors++; $display("FAIL single_edge2: got we=%0b addr=%0d data=%h exp 1/5/64", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'h64}) begin errors++; $display("FAIL single_hold: got we=%0b addr=%0d data=%h exp 0/5/64", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_backpressure();
        logic [36:0] exp_seq [5];
        exp_seq[0] = {5'd20, 32'hB1};
        exp_seq[1] = {5'd12, 32'hA1};
        exp_seq[2] = {5'd21, 32'hB2};
        exp_seq[3] = {5'd13, 32'hA2};
        exp_seq[4] = {5'd14, 32'hA3};
        a_valid = 1; a_addr = 5'd12; a_data = 32'hA1;
        b_valid = 1; b_addr = 5'd20; b_data = 32'hB1;
        tick();
        a_addr = 5'd13; a_data = 32'hA2; b_addr = 5'd21; b_data = 32'hB2;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %0b exp 1", a_ready); end
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) begin
                a_addr = 5'd14; a_data = 32'hA3; b_valid = 0;
                checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %0b exp 0", a_ready); end
            end
            if (k == 1) begin
                checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_drain: got %0b exp 1", a_ready); end
            end
            if (k == 2) a_valid = 0;
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, exp_seq[k]}) begin
                errors++;
                $display("FAIL bp_order[%0d]: got we=%0b addr=%0d data=%h exp 1/%0d/%h", k, rf_we, rf_waddr, rf_wdata, exp_seq[k][36:32], exp_seq[k][31:0]);
            end
        end
        tick();
        checks++; if ({rf_we, busy} !== 2'b00) begin errors++; $display("FAIL bp_idle: got we=%0b busy=%0b exp 0/0", rf_we, busy); end
    endtask

    task automatic test_zero();
        b_valid = 1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF; rd1_addr = 5'd0;
        tick();
        b_valid = 0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_queued: got busy=%0b exp 1", busy); end
        checks++; if (rd1_pending !== 1'b0) begin errors++; $display("FAIL zero_pending: got %0b exp 0", rd1_pending); end
        tick();
        checks++; if ({rf_we, busy} !== 2'b00) begin errors++; $display("FAIL zero_no_write: got we=%0b busy=%0b exp 0/0", rf_we, busy); end
    endtask

    task automatic test_pending();
        rd1_addr = 5'd7; rd2_addr = 5'd8;
        a_valid = 1; a_addr = 5'd7; a_data = 32'h1;
        tick();
        a_data = 32'h2;
        checks++; if ({rd1_pending, rd2_pending} !== 2'b10) begin errors++; $display("FAIL pend_fifo: got %b exp 10", {rd1_pending, rd2_pending}); end
        tick();
        a_valid = 0;
        checks++; if (rd1_pending !== 1'b1) begin errors++; $display("FAIL pend_chain: got %0b exp 1", rd1_pending); end
`ifdef RF_WB_BYPASS_EN
        checks++; if ({rd1_fwd_valid, rd1_fwd_data} !== {1'b1, 32'h2}) begin errors++; $display("FAIL fwd_youngest: got v=%0b d=%h exp 1/2", rd1_fwd_valid, rd1_fwd_data); end
`endif
        tick();
        checks++; if (rd1_pending !== 1'b1) begin errors++; $display("FAIL pend_outreg: got %0b exp 1", rd1_pending); end
`ifdef RF_WB_BYPASS_EN
        checks++; if ({rd1_fwd_valid, rd1_fwd_data} !== {1'b1, 32'h2}) begin errors++; $display("FAIL fwd_outreg: got v=%0b d=%h exp 1/2", rd1_fwd_valid, rd1_fwd_data); end
`endif
        tick();
        checks++; if (rd1_pending !== 1'b0) begin errors++; $display("FAIL pend_clear: got %0b exp 0", rd1_pending); end
        a_valid = 1; a_data = 32'h1;
        tick();
        a_data = 32'h2; b_valid = 1; b_addr = 5'd7; b_data = 32'h3; rd2_addr = 5'd7;
        tick();
        a_valid = 0; b_valid = 0;
        checks++; if ({rd1_pending, rd2_pending} !== 2'b11) begin errors++; $display("FAIL pend_both: got %b exp 11", {rd1_pending, rd2_pending}); end
`ifdef RF_WB_BYPASS_EN
        checks++; if ({rd1_fwd_valid, rd1_fwd_data} !== {1'b0, 32'h0}) begin errors++; $display("FAIL fwd_split: got v=%0b d=%h exp 0/0", rd1_fwd_valid, rd1_fwd_data); end
        checks++; if (rd2_fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_split2: got v=%0b exp 0", rd2_fwd_valid); end
`endif
        tick();
        checks++; if ({rf_we, rf_wdata} !== {1'b1, 32'h3}) begin errors++; $display("FAIL pend_rr_b: got we=%0b data=%h exp 1/3", rf_we, rf_wdata); end
        tick();
        checks++; if ({rf_we, rf_wdata} !== {1'b1, 32'h2}) begin errors++; $display("FAIL pend_rr_a: got we=%0b data=%h exp 1/2", rf_we, rf_wdata); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pend_drain: got busy=%0b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        rd1_addr = 5'd1; rd2_addr = 5'd0;
        a_valid = 1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1; b_addr = 5'd2; b_data = 32'h22;
        tick();
        a_addr = 5'd3; a_data = 32'h33; b_valid = 0;
        tick();
        a_valid = 0;
        checks++; if ({rf_we, rf_waddr, rd1_pending} !== {1'b1, 5'd2, 1'b1}) begin errors++; $display("FAIL mid_before: got we=%0b addr=%0d pend=%0b exp 1/2/1", rf_we, rf_waddr, rd1_pending); end
        rst_n = 1'b0;
        #1;
        checks++; if ({rf_we, busy, rd1_pending} !== 3'b000) begin errors++; $display("FAIL mid_async: got we=%0b busy=%0b pend=%0b exp 000", rf_we, busy, rd1_pending); end
        checks++; if ({a_ready, b_ready} !== 2'b11) begin errors++; $display("FAIL mid_ready: got %b exp 11", {a_ready, b_ready}); end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if ({rf_we, busy} !== 2'b00) begin errors++; $display("FAIL mid_discard[%0d]: got we=%0b busy=%0b exp 0/0", k, rf_we, busy); end
        end
    endtask

    initial begin
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        rd1_addr = 0; rd2_addr = 0;
        test_reset();
        test_tie();
        test_single();
        test_backpressure();
        test_zero();
        test_pending();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
